// File: rtl/vec_mem_sequencer.sv
// Memory-stage sequencer: issues scalar accesses as one word and vector accesses as
// LANES consecutive words on a single data-memory port, stalling the front of the pipe.
module vec_mem_sequencer #(
    parameter int LANES       = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_STRIDE = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [LANES*DATA_WIDTH-1:0]   ALUResultM,
    input  logic [LANES*DATA_WIDTH-1:0]   WriteDataM,
    input  logic                          MemWriteM,
    input  logic                          MemtoRegM,
    input  logic                          v_s_m,
    output logic [DATA_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    output logic                          mem_we,
    output logic                          mem_re,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    output logic                          stall,
    output logic                          busy,
    output logic [LANES*DATA_WIDTH-1:0]   ReadDataM
);

    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [2:0] {IDLE, STORE, LOAD, DRAIN, DONE} state_t;

    state_t                        stateReg, stateNext;
    logic [IDX_W-1:0]              idxReg, idxNext;
    logic [IDX_W-1:0]              lastReg;
    logic [IDX_W-1:0]              pipeIdxReg;
    logic                          pipeValidReg;
    logic [DATA_WIDTH-1:0]         baseReg;
    logic [LANES*DATA_WIDTH-1:0]   wbufFlat;
    logic [DATA_WIDTH-1:0]         laneAddr;
    logic                          req;
    logic                          captureReq;
    logic                          loadStart;
    logic                          unusedAluLanes;

    // Only lane 0 of the ALU result carries the base address.
    assign unusedAluLanes = ^ALUResultM;

    assign req        = MemWriteM | MemtoRegM;
    assign captureReq = (stateReg == IDLE) && req;
    assign loadStart  = captureReq && !MemWriteM;
    assign laneAddr   = baseReg + (DATA_WIDTH'(idxReg) * DATA_WIDTH'(ADDR_STRIDE));

    always_ff @(posedge CLK) begin
        if (RST) begin
            stateReg     <= IDLE;
            idxReg       <= '0;
            lastReg      <= '0;
            baseReg      <= '0;
            pipeValidReg <= 1'b0;
            pipeIdxReg   <= '0;
        end else begin
            stateReg     <= stateNext;
            idxReg       <= idxNext;
            pipeValidReg <= (stateReg == LOAD);
            pipeIdxReg   <= idxReg;
            if (captureReq) begin
                baseReg <= ALUResultM[DATA_WIDTH-1:0];
                lastReg <= v_s_m ? IDX_W'(LANES - 1) : '0;
            end
        end
    end

    // Per-lane write buffer and read-assembly registers.
    for (genvar gi = 0; gi < LANES; gi++) begin : laneGen
        logic [DATA_WIDTH-1:0] wLaneReg;
        logic [DATA_WIDTH-1:0] rLaneReg;

        always_ff @(posedge CLK) begin
            if (RST) begin
                wLaneReg <= '0;
                rLaneReg <= '0;
            end else begin
                if (captureReq) begin
                    wLaneReg <= WriteDataM[gi*DATA_WIDTH +: DATA_WIDTH];
                end
                if (loadStart) begin
                    rLaneReg <= '0;
                end else if (pipeValidReg && (pipeIdxReg == IDX_W'(gi))) begin
                    rLaneReg <= mem_rdata;
                end
            end
        end

        assign wbufFlat[gi*DATA_WIDTH +: DATA_WIDTH]  = wLaneReg;
        assign ReadDataM[gi*DATA_WIDTH +: DATA_WIDTH] = rLaneReg;
    end

    always_comb begin
        stateNext = stateReg;
        idxNext   = idxReg;
        stall     = 1'b0;
        busy      = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (stateReg)
            IDLE: begin
                stall = req;
                if (req) begin
                    idxNext   = '0;
                    stateNext = MemWriteM ? STORE : LOAD;
                end
            end
            STORE: begin
                stall     = 1'b1;
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = laneAddr;
                mem_wdata = wbufFlat[idxReg*DATA_WIDTH +: DATA_WIDTH];
                if (idxReg == lastReg) begin
                    stateNext = DONE;
                end else begin
                    idxNext = idxReg + 1'b1;
                end
            end
            LOAD: begin
                stall    = 1'b1;
                busy     = 1'b1;
                mem_re   = 1'b1;
                mem_addr = laneAddr;
                if (idxReg == lastReg) begin
                    stateNext = DRAIN;
                end else begin
                    idxNext = idxReg + 1'b1;
                end
            end
            DRAIN: begin
                stall     = 1'b1;
                busy      = 1'b1;
                stateNext = DONE;
            end
            DONE: begin
                // The request is still visible here but belongs to the retiring op.
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Self-checking bench for vec_mem_sequencer: per-cycle expectations derived from the
// access rules, plus a small memory model answering reads one cycle after mem_re.
module tb_vec_mem_sequencer;

    localparam int LANES  = 16;
    localparam int DW     = 32;
    localparam int STRIDE = 4;
    localparam int VW     = LANES * DW;

    logic          CLK = 1'b0;
    logic          RST;
    logic [VW-1:0] ALUResultM;
    logic [VW-1:0] WriteDataM;
    logic          MemWriteM;
    logic          MemtoRegM;
    logic          v_s_m;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_rdata = '0;
    logic          stall;
    logic          busy;
    logic [VW-1:0] ReadDataM;

    always #5 CLK = ~CLK;

    vec_mem_sequencer #(.LANES(LANES), .DATA_WIDTH(DW), .ADDR_STRIDE(STRIDE)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .MemWriteM  (MemWriteM),
        .MemtoRegM  (MemtoRegM),
        .v_s_m      (v_s_m),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
        .stall      (stall),
        .busy       (busy),
        .ReadDataM  (ReadDataM)
    );

    // Sparse word memory; untouched words return an address-derived pattern.
    logic [31:0] memArr [logic [31:0]];

    function automatic logic [31:0] memPeek(input logic [31:0] a);
        if (memArr.exists(a)) return memArr[a];
        return a ^ 32'h5A5A_0F0F;
    endfunction

    always @(posedge CLK) begin
        if (mem_re) mem_rdata <= memPeek(mem_addr);
        if (mem_we) memArr[mem_addr] = mem_wdata;
    end

    typedef struct {
        bit          stall;
        bit          busy;
        bit          we;
        bit          re;
        bit          chkRd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [VW-1:0] rd;
    } exp_t;

    exp_t          expQ[$];
    int            errors  = 0;
    int            checks  = 0;
    bit            checkEn = 1'b0;
    logic [VW-1:0] rdModel = '0;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Single compare process: every cycle is either an expected step or plain idle.
    always @(negedge CLK) begin
        if (checkEn) begin
            exp_t e;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
            end else begin
                e.stall = 0; e.busy = 0; e.we = 0; e.re = 0; e.chkRd = 1;
                e.addr = '0; e.wdata = '0; e.rd = rdModel;
            end
            chk("stall", VW'(stall), VW'(e.stall));
            chk("busy", VW'(busy), VW'(e.busy));
            chk("mem_we", VW'(mem_we), VW'(e.we));
            chk("mem_re", VW'(mem_re), VW'(e.re));
            if (e.we || e.re || (!e.we && !e.re)) chk("mem_addr", VW'(mem_addr), VW'(e.addr));
            if (!e.re) chk("mem_wdata", VW'(mem_wdata), VW'(e.wdata));
            if (e.chkRd) chk("ReadDataM", ReadDataM, e.rd);
        end
    end

    function automatic logic [VW-1:0] randVec();
        logic [VW-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*DW +: DW] = $urandom;
        return v;
    endfunction

    // Builds the cycle-by-cycle expectation of one operation, starting at the request cycle.
    function automatic int pushOp(input bit isSt, input bit isLd, input bit vec,
                                  input logic [31:0] base, input logic [VW-1:0] wd);
        int            n  = vec ? LANES : 1;
        bit            st = isSt;
        bit            ld = !isSt && isLd;
        int            cnt = 0;
        exp_t          e;
        logic [VW-1:0] newRd = '0;
        e.stall = 1; e.busy = 0; e.we = 0; e.re = 0; e.chkRd = 1;
        e.addr = '0; e.wdata = '0; e.rd = rdModel;
        expQ.push_back(e); cnt++;
        for (int i = 0; i < n; i++) begin
            e.stall = 1; e.busy = 1; e.we = st; e.re = ld; e.chkRd = st;
            e.addr  = base + 32'(i * STRIDE);
            e.wdata = st ? wd[i*DW +: DW] : 32'h0;
            e.rd    = rdModel;
            expQ.push_back(e); cnt++;
            if (ld) newRd[i*DW +: DW] = memPeek(base + 32'(i * STRIDE));
        end
        if (ld) begin
            e.stall = 1; e.busy = 1; e.we = 0; e.re = 0; e.chkRd = 0;
            e.addr = '0; e.wdata = '0;
            expQ.push_back(e); cnt++;
            rdModel = newRd;
        end
        e.stall = 0; e.busy = 0; e.we = 0; e.re = 0; e.chkRd = 1;
        e.addr = '0; e.wdata = '0; e.rd = rdModel;
        expQ.push_back(e); cnt++;
        return cnt;
    endfunction

    // Called just after a rising edge; returns just after the edge that ends DONE.
    task automatic runOp(input bit isSt, input bit isLd, input bit vec,
                         input logic [31:0] base, input logic [VW-1:0] wd, input bit scramble);
        int n;
        MemWriteM  = isSt;
        MemtoRegM  = isLd;
        v_s_m      = vec;
        ALUResultM = randVec();
        ALUResultM[DW-1:0] = base;
        WriteDataM = wd;
        n = pushOp(isSt, isLd, vec, base, wd);
        $display("op t=%0t we=%0b re=%0b vec=%0b base=%08h cycles=%0d", $time, isSt, isLd, vec, base, n);
        for (int k = 1; k < n; k++) begin
            @(posedge CLK); #1;
            if (scramble) begin
                ALUResultM = randVec();
                WriteDataM = randVec();
                v_s_m      = 1'($urandom);
            end
        end
        @(posedge CLK); #1;
        MemWriteM = 1'b0;
        MemtoRegM = 1'b0;
    endtask

    initial begin
        logic [VW-1:0] wd;
        int            n;

        // Reset held with a store pending: nothing may reach memory.
        RST = 1'b1; MemWriteM = 1'b1; MemtoRegM = 1'b0; v_s_m = 1'b1;
        ALUResultM = '0; ALUResultM[DW-1:0] = 32'h500;
        WriteDataM = randVec();
        repeat (2) begin
            @(posedge CLK); #1;
            chk("rst_we", VW'(mem_we), '0);
            chk("rst_re", VW'(mem_re), '0);
            chk("rst_busy", VW'(busy), '0);
            chk("rst_rd", ReadDataM, '0);
            chk("rst_stall", VW'(stall), VW'(1'b1));
        end
        RST = 1'b0;
        checkEn = 1'b1;
        runOp(1, 0, 1, 32'h500, WriteDataM, 0);

        // Vector store, lane i = 0xA0+i.
        for (int i = 0; i < LANES; i++) wd[i*DW +: DW] = 32'hA0 + 32'(i);
        runOp(1, 0, 1, 32'h100, wd, 0);
        chk("pin_mem100", VW'(memPeek(32'h100)), VW'(32'hA0));
        chk("pin_mem13C", VW'(memPeek(32'h13C)), VW'(32'hAF));

        // Vector load from a preloaded block.
        for (int i = 0; i < LANES; i++) memArr[32'h200 + 32'(4*i)] = 32'h1000 + 32'(i);
        runOp(0, 1, 1, 32'h200, randVec(), 0);
        chk("pin_vload_l5", VW'(ReadDataM[5*DW +: DW]), VW'(32'h1005));
        chk("pin_vload_l15", VW'(ReadDataM[15*DW +: DW]), VW'(32'h100F));

        // Scalar load fills lane 0 only.
        memArr[32'h40] = 32'hDEADBEEF;
        runOp(0, 1, 0, 32'h40, randVec(), 0);
        chk("pin_sload_l0", VW'(ReadDataM[DW-1:0]), VW'(32'hDEADBEEF));
        chk("pin_sload_hi", VW'(ReadDataM[VW-1:DW]), '0);

        // Address wrap past the top of the space, with inputs wiggling mid-op.
        wd = randVec();
        runOp(1, 0, 1, 32'hFFFF_FFF8, wd, 1);
        chk("pin_wrap_0", VW'(memPeek(32'h0)), VW'(wd[2*DW +: DW]));
        chk("pin_wrap_34", VW'(memPeek(32'h34)), VW'(wd[15*DW +: DW]));

        // Store and load both requested: a single scalar write wins.
        wd = randVec();
        runOp(1, 1, 0, 32'h80, wd, 0);
        chk("pin_both_80", VW'(memPeek(32'h80)), VW'(wd[DW-1:0]));

        // Reset during the lane-5 read of a vector load.
        @(posedge CLK); #1;
        MemtoRegM = 1'b1; MemWriteM = 1'b0; v_s_m = 1'b1;
        ALUResultM = randVec(); ALUResultM[DW-1:0] = 32'h300;
        n = pushOp(0, 1, 1, 32'h300, '0);
        while (expQ.size() > 7) void'(expQ.pop_back());
        $display("op t=%0t load vec base=00000300 reset at lane 5 (planned %0d cycles)", $time, n);
        repeat (6) begin @(posedge CLK); #1; end
        RST = 1'b1; MemtoRegM = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        rdModel = '0;
        repeat (3) begin @(posedge CLK); #1; end

        // Randomized mix of scalar/vector loads and stores.
        for (int t = 0; t < 30; t++) begin
            bit st, ld, vec;
            logic [31:0] base;
            st   = 1'($urandom);
            ld   = st ? 1'($urandom) : 1'b1;
            vec  = 1'($urandom);
            base = ($urandom_range(0, 3) == 0) ? $urandom : (32'h1000 + ($urandom_range(0, 63) << 2));
            runOp(st, ld, vec, base, randVec(), 1'($urandom));
            repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
        end

        repeat (3) @(posedge CLK);
        #1;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations: got %0d pending expected 0", expQ.size());
        end
        checks++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
